// File: rtl/axi_memory_slave_burst.sv
// axi_memory_slave_burst
// AXI4 burst-capable memory slave backed by a byte-addressable register array.
// It accepts one write burst and one read burst at a time. The write and read
// channels are independent of each other. Byte strobes are honoured, FIXED and
// INCR addressing are supported, and each burst ends with an OKAY or SLVERR
// response.
//
// Optional feature: define AXI_SLAVE_WRAP_BURST_EN to decode burst type 2'b10 as
// WRAP. When the macro is undefined, 2'b10 is handled as INCR and returns OKAY.
//
// Ports:
//   clk, resetn                              clock, async active-low reset
//   aw{id,addr,len,size,burst,valid,ready}   write address channel
//   w{data,strb,last,valid,ready}            write data channel
//   b{id,resp,valid,ready}                   write response channel
//   ar{id,addr,len,size,burst,valid,ready}   read address channel
//   r{id,data,resp,last,valid,ready}         read data channel
module axi_memory_slave_burst #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_SLAVE_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Returns {err, effective burst type, effective size} for an address request.
  function automatic logic [5:0] decode_burst(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [7:0]            len,
                                              input logic [2:0]            size,
                                              input logic [1:0]            burst);
    logic       err;
    logic [2:0] sz;
    logic [1:0] bt;
    logic       len_ok;
    logic       aligned;
    err = 1'b0;
    sz  = size;
    if (size > 3'(OFFS)) begin
      sz  = 3'(OFFS);
      err = 1'b1;
    end
    len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    aligned = (addr & ((ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1))) == '0;
    case (burst)
      2'b00: bt = BT_FIXED;
      2'b10: begin
        if (WRAP_EN && len_ok && aligned) begin
          bt = BT_WRAP;
        end else begin
          // An illegal WRAP falls back to INCR. It is an error only when WRAP is enabled.
          bt  = BT_INCR;
          err = err | WRAP_EN;
        end
      end
      2'b11: begin
        bt  = BT_INCR;
        err = 1'b1;
      end
      default: bt = BT_INCR;
    endcase
    decode_burst = {err, bt, sz};
  endfunction

  // Address of the next beat. WRAP keeps the address inside its aligned block.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            sz,
                                                      input logic [7:0]            len,
                                                      input logic [1:0]            bt);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] sum;
    inc  = ADDR_WIDTH'(1) << sz;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    sum  = a + inc;
    case (bt)
      BT_FIXED: next_addr = a;
      BT_WRAP:  next_addr = (a & ~mask) | (sum & mask);
      default:  next_addr = sum;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Write channel state
  w_state_e              w_state_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [7:0]            w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_bt_q;
  logic                  w_err_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;

  logic [5:0]            aw_dec_c;
  logic                  w_oob_c;
  logic                  w_last_beat_c;
  logic                  w_beat_err_c;
  logic [IDX_W-1:0]      w_idx_c;

  assign aw_dec_c      = decode_burst(awaddr, awlen, awsize, awburst);
  assign w_oob_c       = (w_addr_q >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
  assign w_idx_c       = IDX_W'(w_addr_q >> OFFS);
  assign w_last_beat_c = (w_cnt_q == w_len_q);
  // The burst length is fixed by awlen. A misplaced wlast only flags an error.
  assign w_beat_err_c  = w_oob_c | (wlast != w_last_beat_c);

  // Write FSM: address accept, data beats, then response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_bt_q    <= BT_INCR;
      w_err_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid) begin
            bid_q     <= awid;
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_size_q  <= aw_dec_c[2:0];
            w_bt_q    <= aw_dec_c[4:3];
            w_err_q   <= aw_dec_c[5];
            w_cnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (w_last_beat_c) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q | w_beat_err_c) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q  <= w_cnt_q + 8'd1;
              w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_bt_q);
              w_err_q  <= w_err_q | w_beat_err_c;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Storage array: byte-lane writes. Out-of-range beats are dropped. No reset.
  always_ff @(posedge clk) begin
    if ((w_state_q == W_DATA) && wvalid && !w_oob_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem_q[w_idx_c][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read channel state
  r_state_e              r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_bt_q;
  logic                  r_err_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q;

  logic [5:0]            ar_dec_c;
  logic                  r_oob_c;
  logic [IDX_W-1:0]      r_idx_c;

  assign ar_dec_c = decode_burst(araddr, arlen, arsize, arburst);
  assign r_oob_c  = (r_addr_q >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
  assign r_idx_c  = IDX_W'(r_addr_q >> OFFS);

  // Read FSM: address accept, then one beat per rready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_bt_q    <= BT_INCR;
      r_err_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid) begin
            rid_q     <= arid;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= ar_dec_c[2:0];
            r_bt_q    <= ar_dec_c[4:3];
            r_err_q   <= ar_dec_c[5];
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_cnt_q == r_len_q) begin
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_addr_q <= next_addr(r_addr_q, r_size_q, r_len_q, r_bt_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  // Read beat payload is derived from registered state only and is zero while idle.
  assign rdata   = (rvalid_q && !r_oob_c) ? mem_q[r_idx_c] : '0;
  assign rresp   = (rvalid_q && (r_err_q || r_oob_c)) ? RESP_SLVERR : RESP_OKAY;
  assign rlast   = rvalid_q && (r_cnt_q == r_len_q);

endmodule

// File: tb/tb_axi_memory_slave_burst.sv
// Randomised bench for axi_memory_slave_burst with a word-array reference model.
module tb_axi_memory_slave_burst;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned MD = 1024;
  localparam int unsigned XW = $clog2(MD);

  logic          clk;
  logic          resetn;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_memory_slave_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(MD)) dut (
    .clk(clk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0]  ref_mem [MD];
  int unsigned  plan_addr[$];
  bit           plan_err;
  logic [31:0]  wq_data[$];
  logic [3:0]   wq_strb[$];
  logic [31:0]  rd_obs[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat addresses and the burst-level error for a request, from the protocol rules.
  task automatic plan_burst(input int unsigned addr, input int unsigned len,
                            input int unsigned size, input int unsigned burst);
    int unsigned sz, step, blk, base, a;
    int mode;
    plan_addr.delete();
    plan_err = 1'b0;
    sz = size;
    if (size > 2) begin sz = 2; plan_err = 1'b1; end
    step = 1 << sz;
    mode = (burst == 0) ? 0 : 1;
    if (burst == 3) plan_err = 1'b1;
`ifdef AXI_SLAVE_WRAP_BURST_EN
    if (burst == 2) begin
      if ((len == 1 || len == 3 || len == 7 || len == 15) && (addr % step) == 0) mode = 2;
      else plan_err = 1'b1;
    end
`endif
    blk  = (len + 1) * step;
    base = addr - (addr % blk);
    a    = addr;
    for (int i = 0; i <= int'(len); i++) begin
      plan_addr.push_back(a);
      if (mode == 1) a = a + step;
      else if (mode == 2) a = base + ((a + step - base) % blk);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_awready", 64'(awready), 64'd1);
    check_eq("rst_arready", 64'(arready), 64'd1);
    check_eq("rst_wready",  64'(wready),  64'd0);
    check_eq("rst_bvalid",  64'(bvalid),  64'd0);
    check_eq("rst_rvalid",  64'(rvalid),  64'd0);
    check_eq("rst_rlast",   64'(rlast),   64'd0);
    check_eq("rst_bid",     64'(bid),     64'd0);
    check_eq("rst_rid",     64'(rid),     64'd0);
    check_eq("rst_bresp",   64'(bresp),   64'd0);
    check_eq("rst_rresp",   64'(rresp),   64'd0);
    check_eq("rst_rdata",   64'(rdata),   64'd0);
  endtask

  // Full write transaction using wq_data/wq_strb; optionally misplaces wlast once.
  task automatic do_write(input logic [IW-1:0] id, input int unsigned addr, input int unsigned len,
                          input int unsigned size, input int unsigned burst, input bit bad_last);
    bit err;
    int bad_beat;
    int unsigned n, idx;
    logic wl;
    plan_burst(addr, len, size, burst);
    err = plan_err;
    bad_beat = bad_last ? int'($urandom_range(0, len)) : -1;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check_eq("awready", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    check_eq("wready_after_aw", 64'(wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wl = (i == int'(len)) ^ (i == bad_beat);
      wvalid = 1'b1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = wl;
      check_eq("wready_beat", 64'(wready), 64'd1);
      @(negedge clk);
      if (wl != (i == int'(len))) err = 1'b1;
      idx = plan_addr[i] >> 2;
      if (idx >= MD) err = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (wq_strb[i][b]) ref_mem[XW'(idx)][b*8 +: 8] = wq_data[i][b*8 +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq("bvalid_next", 64'(bvalid), 64'd1);
    check_eq("bid", 64'(bid), 64'(id));
    check_eq("bresp", 64'(bresp), err ? 64'd2 : 64'd0);
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      check_eq("bvalid_hold", 64'(bvalid), 64'd1);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("bvalid_clear", 64'(bvalid), 64'd0);
    check_eq("awready_back", 64'(awready), 64'd1);
  endtask

  // Full read transaction. mode 0: random rready, 1: toggling, 2: continuous.
  task automatic do_read(input logic [IW-1:0] id, input int unsigned addr, input int unsigned len,
                         input int unsigned size, input int unsigned burst, input int mode);
    logic [31:0] exp_d[$];
    logic [1:0]  exp_r[$];
    int unsigned idx, n, beat, guard;
    bit rr, tog;
    logic [31:0] obs;
    plan_burst(addr, len, size, burst);
    rd_obs.delete();
    for (int i = 0; i <= int'(len); i++) begin
      idx = plan_addr[i] >> 2;
      if (idx >= MD) begin exp_d.push_back(32'h0); exp_r.push_back(2'b10); end
      else begin
        exp_d.push_back(ref_mem[XW'(idx)]);
        exp_r.push_back(plan_err ? 2'b10 : 2'b00);
      end
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check_eq("arready", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("rvalid_after_ar", 64'(rvalid), 64'd1);
    beat = 0; guard = 0; tog = 1'b0;
    while (beat <= len && guard < 4000) begin
      check_eq("rvalid", 64'(rvalid), 64'd1);
      check_eq("rdata", 64'(rdata), 64'(exp_d[beat]));
      check_eq("rresp", 64'(rresp), 64'(exp_r[beat]));
      check_eq("rlast", 64'(rlast), 64'(beat == len));
      check_eq("rid", 64'(rid), 64'(id));
      case (mode)
        0: rr = ($urandom_range(0, 2) != 0);
        1: begin rr = tog; tog = !tog; end
        default: rr = 1'b1;
      endcase
      rready = rr;
      obs = rdata;
      @(negedge clk);
      if (rr) begin rd_obs.push_back(obs); beat++; end
      guard++;
    end
    rready = 1'b0;
    check_eq("read_beats", 64'(beat), 64'(len + 1));
    check_eq("rvalid_clear", 64'(rvalid), 64'd0);
    check_eq("rdata_idle", 64'(rdata), 64'd0);
    check_eq("rlast_idle", 64'(rlast), 64'd0);
    check_eq("arready_back", 64'(arready), 64'd1);
  endtask

  task automatic fill_wq(input int unsigned len, input bit rand_strb);
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i <= int'(len); i++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(rand_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d0, d1;
    resetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;

    // Known contents everywhere, via four 256-beat INCR bursts
    for (int blk = 0; blk < 4; blk++) begin
      fill_wq(255, 1'b0);
      do_write(4'(blk), int'(blk) * 1024, 255, 2, 1, 1'b0);
    end

    // Basic INCR write then read back with toggling rready
    wq_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd3, 32'h10, 3, 2, 1, 1'b0);
    do_read(4'd3, 32'h10, 3, 2, 1, 1);
    for (int i = 0; i < 4; i++) check_eq("incr_readback", 64'(rd_obs[i]), 64'(32'hA0 + i));

    // Partial strobe merge
    wq_data = '{32'h12345678}; wq_strb = '{4'hF};
    do_write(4'd1, 32'h100, 0, 2, 1, 1'b0);
    wq_data = '{32'hFFFFFFFF}; wq_strb = '{4'h3};
    do_write(4'd2, 32'h100, 0, 2, 1, 1'b0);
    do_read(4'd2, 32'h100, 0, 2, 1, 2);
    check_eq("strb_merge", 64'(rd_obs[0]), 64'h1234FFFF);

    // Out-of-range word: write dropped, read returns zero with SLVERR
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    do_write(4'd7, MD * 4, 0, 2, 1, 1'b0);
    do_read(4'd7, MD * 4, 0, 2, 1, 2);
    check_eq("oob_rdata", 64'(rd_obs[0]), 64'd0);
    do_read(4'd7, 0, 0, 2, 1, 2);
    do_read(4'd7, (MD - 1) * 4, 1, 2, 1, 0);

    // WRAP vs INCR for burst type 2'b10
    wq_data = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd0, 32'h10, 5, 2, 1, 1'b0);
    wq_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd9, 32'h18, 3, 2, 2, 1'b0);
    do_read(4'd9, 32'h10, 5, 2, 1, 2);
`ifdef AXI_SLAVE_WRAP_BURST_EN
    check_eq("wrap_w4", 64'(rd_obs[0]), 64'hB2);
    check_eq("wrap_w5", 64'(rd_obs[1]), 64'hB3);
    check_eq("wrap_w6", 64'(rd_obs[2]), 64'hB0);
    check_eq("wrap_w9", 64'(rd_obs[5]), 64'hC5);
`else
    check_eq("wrap_w4", 64'(rd_obs[0]), 64'hC0);
    check_eq("wrap_w6", 64'(rd_obs[2]), 64'hB0);
    check_eq("wrap_w8", 64'(rd_obs[4]), 64'hB2);
    check_eq("wrap_w9", 64'(rd_obs[5]), 64'hB3);
`endif

    // Simultaneous AW and AR, then reset in the middle of both bursts
    d0 = $urandom; d1 = $urandom;
    @(negedge clk);
    awid = 4'd5; awaddr = 32'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd6; araddr = 32'h80; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    check_eq("dual_wready", 64'(wready), 64'd1);
    check_eq("dual_rvalid", 64'(rvalid), 64'd1);
    check_eq("dual_awready", 64'(awready), 64'd0);
    check_eq("dual_arready", 64'(arready), 64'd0);
    check_eq("dual_rid", 64'(rid), 64'd6);
    check_eq("dual_rdata0", 64'(rdata), 64'(ref_mem[XW'(32'h20)]));
    wvalid = 1'b1; wdata = d0; wstrb = 4'hF; wlast = 1'b0; rready = 1'b1;
    @(negedge clk);
    ref_mem[XW'(32'h10)] = d0;
    check_eq("dual_rdata1", 64'(rdata), 64'(ref_mem[XW'(32'h21)]));
    check_eq("dual_rlast1", 64'(rlast), 64'd0);
    wdata = d1;
    @(negedge clk);
    ref_mem[XW'(32'h11)] = d1;
    resetn = 1'b0; wvalid = 1'b0; rready = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    do_read(4'd8, 32'h40, 3, 2, 1, 0);
    check_eq("partial_w0", 64'(rd_obs[0]), 64'(d0));
    check_eq("partial_w1", 64'(rd_obs[1]), 64'(d1));

    // Randomised bursts: write then read the same region
    for (int t = 0; t < 40; t++) begin
      int unsigned addr, len, size, burst;
      addr  = $urandom_range(0, MD * 4 + 40);
      len   = $urandom_range(0, 7);
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      fill_wq(len, 1'b1);
      do_write(4'($urandom_range(0, 15)), addr, len, size, burst, ($urandom_range(0, 7) == 0));
      do_read(4'($urandom_range(0, 15)), addr, len, size, burst, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_memory_slave_burst.md
# axi_memory_slave_burst

AXI4 burst-capable memory slave that sits directly downstream of the AXI memory master, terminating its write and read channels in a byte-addressable register-array memory. It accepts one write burst and one read burst at a time on independent channels, honours byte strobes and INCR/FIXED burst addressing, and reports OKAY/SLVERR responses. It serves as the frame-buffer model and on-chip scratch memory behind the master in simulation and synthesis.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width (multiple of 8, power of 2)
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- awvalid in 1, awready out 1  write address handshake
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid out 1, bready in 1  write response handshake
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
- rvalid out 1, rready in 1  read data handshake

## Operation
- Write FSM: W_IDLE -> (awvalid) W_DATA -> (beat with beat_cnt==len) W_RESP -> (bready) W_IDLE.
- W_IDLE: awready=1; on handshake latch id, addr, len, size, burst; beat_cnt=0; err=0.
- W_DATA: wready=1; each wvalid beat writes byte lanes where wstrb=1 at word addr>>log2(DATA_WIDTH/8); beat_cnt+1.
- Burst ends at beat len+1 regardless of wlast; wlast missing on last beat or asserted earlier sets err.
- W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if err else 2'b00.
- Read FSM: R_IDLE -> (arvalid) R_DATA -> (rready on rlast beat) R_IDLE.
- R_IDLE: arready=1; latch id/addr/len/size/burst. R_DATA: rvalid=1, rdata=combinational read of current word, rlast=(beat_cnt==len), rid=latched id.
- Address update per accepted beat: INCR adds 1<<size; FIXED holds; reserved burst 2'b11 -> INCR with err/SLVERR.
- size > log2(DATA_WIDTH/8): treated as full width, err set.
- Word index >= MEM_DEPTH: write dropped, read rdata=0, rresp/bresp SLVERR.
- Read/write channels fully independent; AW and AR accepted same cycle.
- Same-word read and write same cycle: read returns pre-write data.

## Timing
- Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0, bresp=0, rresp=0, rdata=0. Memory contents not reset.
- All handshake outputs decoded from state only; no combinational path from any *valid/*ready input to outputs.
- AW accept -> wready next cycle; last W beat -> bvalid next cycle.
- AR accept -> first rvalid next cycle; one beat per cycle under continuous rready; rdata=0 whenever rvalid=0.
- Backpressure: rvalid/rdata/rlast/rresp held stable until rready; bvalid held until bready.
- Reset mid-burst: both FSMs return to IDLE, partial write beats already taken remain in memory.

## Configuration
- AXI_SLAVE_WRAP_BURST_EN defined: burst 2'b10 is WRAP; address wraps within aligned block of (len+1)<<size bytes; len not in {1,3,7,15} or unaligned start -> SLVERR, treated as INCR.
- Undefined: 2'b10 treated as INCR, response OKAY.

## Test plan
- AW addr 0x10, len 3, size 2, INCR; W 0xA0..0xA3 strb 0xF, wlast on 4th -> words 4..7 written, bvalid 1 cycle after, bresp 00, bid echoed.
- Read back addr 0x10 len 3 with rready toggling every cycle -> rdata 0xA0..0xA3, rlast on 4th only, data stable while stalled.
- Write strb 0x3 data 0xFFFFFFFF over word 0x12345678 -> read 0x1234FFFF.
- Write to word MEM_DEPTH -> bresp 10, memory unchanged; read there -> rdata 0, rresp 10.
- With macro: WRAP len 3 size 2 start 0x18 -> beats at 0x18,0x1C,0x10,0x14; without: 0x18..0x24.
- Simultaneous AW and AR, reset asserted mid-read -> all outputs at reset values, next AR accepted normally.
